// File: rtl/saturn_debug_uart_tx_pkg.sv
// Shared definitions for the debug UART transmitter: FSM state encodings,
// board-default baud divider and FIFO depth.
package saturn_debug_uart_tx_pkg;

  // 25 MHz / 115200 baud, rounded
  localparam int DEF_CLKS_PER_BIT = 217;
  localparam int DEF_FIFO_ADDR_W  = 4;
  localparam int DATA_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // One spare bit so the reload value always fits, even for powers of two.
  function automatic int baud_cnt_w(input int clks_per_bit);
    return $clog2(clks_per_bit) + 1;
  endfunction

endpackage

// File: rtl/saturn_debug_uart_tx_if.sv
// Character write channel from the bus into the debug UART.
interface saturn_debug_uart_tx_if;
  import saturn_debug_uart_tx_pkg::*;

  logic [DATA_W-1:0] i_char;
  logic              i_char_valid;
  logic              o_char_ready;

  modport master (
    output i_char,
    output i_char_valid,
    input  o_char_ready
  );

  modport slave (
    input  i_char,
    input  i_char_valid,
    output o_char_ready
  );

endinterface

// File: rtl/saturn_debug_uart_tx_fifo.sv
// Synchronous FIFO buffering characters ahead of the serialiser.
// Full and empty are judged on the registered level before this edge's pop.
module saturn_uart_fifo
  import saturn_debug_uart_tx_pkg::*;
#(
  parameter int FIFO_ADDR_W = DEF_FIFO_ADDR_W,
  parameter int WIDTH       = DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_push_data,
  input  logic                 i_pop,
  output logic [WIDTH-1:0]     o_pop_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [FIFO_ADDR_W:0] o_level
);

  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam int LVL_W = FIFO_ADDR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] r_wr_ptr;
  logic [FIFO_ADDR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]       r_level;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_level    = r_level;

endmodule

// File: rtl/saturn_debug_uart_tx.sv
// Debug character output: buffers bus characters and sends them as 8N1 UART.
//   state | meaning
//   IDLE  | line high, waiting for a queued character
//   START | start bit (low) for one bit time
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (high); pops the next character straight into START
module saturn_debug_uart_tx
  import saturn_debug_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_ADDR_W  = DEF_FIFO_ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  saturn_debug_uart_tx_if.slave bus,
  input  logic                  i_clear_ovf,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic [FIFO_ADDR_W:0]  o_fifo_level,
  output logic                  o_overflow
);

  localparam int BAUD_W = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e         r_state;
  uart_state_e         w_state_nxt;
  logic [BAUD_W-1:0]   r_baud;
  logic [BAUD_W-1:0]   w_baud_nxt;
  logic [2:0]          r_bit;
  logic [2:0]          w_bit_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                r_tx;
  logic                w_tx_nxt;
  logic                r_overflow;
  logic                w_baud_done;
  logic                w_pop;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [DATA_W-1:0]   w_fifo_data;
  logic [FIFO_ADDR_W:0] w_fifo_level;

  saturn_uart_fifo #(
    .FIFO_ADDR_W (FIFO_ADDR_W),
    .WIDTH       (DATA_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (bus.i_char_valid),
    .i_push_data (bus.i_char),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (w_fifo_level)
  );

  assign w_baud_done = (r_baud == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_baud_nxt  = BAUD_RELOAD;
          w_state_nxt = ST_START;
        end
      end

      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_done) begin
          w_baud_nxt  = BAUD_RELOAD;
          w_bit_nxt   = 3'd0;
          w_state_nxt = ST_DATA;
        end else begin
          w_baud_nxt = r_baud - BAUD_W'(1);
        end
      end

      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_done) begin
          w_baud_nxt  = BAUD_RELOAD;
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud - BAUD_W'(1);
        end
      end

      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_done) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_baud_nxt  = BAUD_RELOAD;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - BAUD_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The line level is registered from the current state, so the pin lags
  // the state by one clock and never glitches.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // A write against a full FIFO beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else if (bus.i_char_valid && w_fifo_full) begin
      r_overflow <= 1'b1;
    end else if (i_clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.o_char_ready = !w_fifo_full;
  assign o_tx             = r_tx;
  assign o_busy           = (r_state != ST_IDLE) || (w_fifo_level != '0);
  assign o_fifo_level     = w_fifo_level;
  assign o_overflow       = r_overflow;

endmodule
